// File: rtl/mc_datapath.sv
// mc_datapath: multicycle RV32I datapath (PC, IR, register file, ALU, non-architectural
// latches) stepped one control word per cycle by an external control FSM.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_RegWrite,
  input  logic            i_MemWrite,
  input  logic            i_IRWrite,
  input  logic            i_AdSrc,
  input  logic            i_PCUpdate,
  input  logic            i_Branch,
  input  logic [1:0]      i_ResultSrc,
  input  logic [1:0]      i_ALUSrcA,
  input  logic [1:0]      i_ALUSrcB,
  input  logic [1:0]      i_ALUOp,
  output logic [6:0]      o_opcode,
  output logic            o_zero,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic            o_mem_we,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_e;

  logic [XLEN-1:0] pc_r, old_pc_r, ir_r, data_r, a_r, b_r, alu_out_r;
  logic [XLEN-1:0] rf_r [32];
  logic [XLEN-1:0] rs1_val_s, rs2_val_s, imm_ext_s;
  logic [XLEN-1:0] src_a_s, src_b_s, alu_result_s, result_s;
  logic            pc_write_s;
  alu_ctrl_e       alu_ctrl_s;

  function automatic logic [31:0] imm_decode(input logic [31:0] ir);
    case (ir[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: imm_decode = {{20{ir[31]}}, ir[31:20]};
      7'b0100011: imm_decode = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011: imm_decode = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b1101111: imm_decode = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      default:    imm_decode = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] alu_calc(input alu_ctrl_e ctrl, input logic [31:0] a,
                                           input logic [31:0] b);
    case (ctrl)
      ALU_ADD: alu_calc = a + b;
      ALU_SUB: alu_calc = a - b;
      ALU_SLL: alu_calc = a << b[4:0];
      ALU_SLT: alu_calc = {31'd0, $signed(a) < $signed(b)};
      ALU_XOR: alu_calc = a ^ b;
      ALU_SRL: alu_calc = a >> b[4:0];
      ALU_SRA: alu_calc = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:  alu_calc = a | b;
      ALU_AND: alu_calc = a & b;
      default: alu_calc = a + b;
    endcase
  endfunction

  assign rs1_val_s   = (ir_r[19:15] == 5'd0) ? {XLEN{1'b0}} : rf_r[ir_r[19:15]];
  assign rs2_val_s   = (ir_r[24:20] == 5'd0) ? {XLEN{1'b0}} : rf_r[ir_r[24:20]];
  assign imm_ext_s   = imm_decode(ir_r);
  assign alu_result_s = alu_calc(alu_ctrl_s, src_a_s, src_b_s);
  assign pc_write_s  = i_PCUpdate | (i_Branch & o_zero);

  assign o_opcode    = ir_r[6:0];
  assign o_zero      = (alu_result_s == {XLEN{1'b0}});
  assign o_mem_addr  = i_AdSrc ? result_s : pc_r;
  assign o_mem_wdata = b_r;
  assign o_mem_we    = i_MemWrite;

  // ALU operation select: fixed add/sub, or decoded from funct3/funct7 of the IR
  always_comb begin
    alu_ctrl_s = ALU_ADD;
    case (i_ALUOp)
      2'b00: alu_ctrl_s = ALU_ADD;
      2'b01: alu_ctrl_s = ALU_SUB;
      2'b10: begin
        case (ir_r[14:12])
          3'b000: begin
            // only register-register ops use funct7 to pick subtract
            if ((ir_r[6:0] == 7'b0110011) && ir_r[30]) alu_ctrl_s = ALU_SUB;
            else alu_ctrl_s = ALU_ADD;
          end
          3'b001: alu_ctrl_s = ALU_SLL;
          3'b010: alu_ctrl_s = ALU_SLT;
          3'b100: alu_ctrl_s = ALU_XOR;
          3'b101: begin
            if (ir_r[30]) alu_ctrl_s = ALU_SRA;
            else alu_ctrl_s = ALU_SRL;
          end
          3'b110: alu_ctrl_s = ALU_OR;
          3'b111: alu_ctrl_s = ALU_AND;
          default: alu_ctrl_s = ALU_ADD;
        endcase
      end
      default: alu_ctrl_s = ALU_ADD;
    endcase
  end

  // ALU operand and result muxes
  always_comb begin
    src_a_s  = {XLEN{1'b0}};
    src_b_s  = {XLEN{1'b0}};
    result_s = alu_out_r;
    case (i_ALUSrcA)
      2'b00:   src_a_s = pc_r;
      2'b01:   src_a_s = old_pc_r;
      2'b10:   src_a_s = a_r;
      default: src_a_s = {XLEN{1'b0}};
    endcase
    case (i_ALUSrcB)
      2'b00:   src_b_s = b_r;
      2'b01:   src_b_s = imm_ext_s;
      2'b10:   src_b_s = 32'd4;
      default: src_b_s = {XLEN{1'b0}};
    endcase
    case (i_ResultSrc)
      2'b00:   result_s = alu_out_r;
      2'b01:   result_s = data_r;
      2'b10:   result_s = alu_result_s;
      default: result_s = alu_out_r;
    endcase
  end

  // architectural and latch state; reset overrides any write requested this cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_r      <= RESET_PC;
      old_pc_r  <= RESET_PC;
      ir_r      <= 32'h0000_0013;
      data_r    <= {XLEN{1'b0}};
      a_r       <= {XLEN{1'b0}};
      b_r       <= {XLEN{1'b0}};
      alu_out_r <= {XLEN{1'b0}};
      for (int i = 0; i < 32; i++) rf_r[i] <= {XLEN{1'b0}};
    end else begin
      data_r    <= i_mem_rdata;
      a_r       <= rs1_val_s;
      b_r       <= rs2_val_s;
      alu_out_r <= alu_result_s;
      if (i_IRWrite) begin
        ir_r     <= i_mem_rdata;
        old_pc_r <= pc_r;
      end
      if (pc_write_s) pc_r <= result_s;
      if (i_RegWrite && (ir_r[11:7] != 5'd0)) rf_r[ir_r[11:7]] <= result_s;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: drives multicycle control sequences per instruction,
// predicts outputs from an ISA-level model, and checks them in a separate monitor.
module tb_mc_datapath;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int SEL_OPC = 0, SEL_ZERO = 1, SEL_ADDR = 2, SEL_WDATA = 3, SEL_WE = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_RegWrite = 1'b0, i_MemWrite = 1'b0, i_IRWrite = 1'b0, i_AdSrc = 1'b0;
  logic        i_PCUpdate = 1'b0, i_Branch = 1'b0;
  logic [1:0]  i_ResultSrc = 2'b00, i_ALUSrcA = 2'b00, i_ALUSrcB = 2'b00, i_ALUOp = 2'b00;
  logic [6:0]  o_opcode;
  logic        o_zero, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;

  logic [31:0] mem   [1024];
  logic [31:0] m_mem [1024];
  logic [31:0] m_rf  [32];
  logic [31:0] m_pc, m_old;

  typedef struct { int cyc; string name; int sel; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  mc_datapath #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_RegWrite(i_RegWrite), .i_MemWrite(i_MemWrite),
    .i_IRWrite(i_IRWrite), .i_AdSrc(i_AdSrc), .i_PCUpdate(i_PCUpdate), .i_Branch(i_Branch),
    .i_ResultSrc(i_ResultSrc), .i_ALUSrcA(i_ALUSrcA), .i_ALUSrcB(i_ALUSrcB), .i_ALUOp(i_ALUOp),
    .o_opcode(o_opcode), .o_zero(o_zero), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_we(o_mem_we), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;
  assign i_mem_rdata = mem[o_mem_addr[11:2]];

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  // monitor: pop every expectation due this cycle and compare against the live outputs
  always @(negedge i_clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_OPC:   act = {25'd0, o_opcode};
        SEL_ZERO:  act = {31'd0, o_zero};
        SEL_ADDR:  act = o_mem_addr;
        SEL_WDATA: act = o_mem_wdata;
        default:   act = {31'd0, o_mem_we};
      endcase
      n_tests++;
      if (e.cyc != cyc_cnt || act !== e.val) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, e.cyc, act, e.val);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // RV32I integer op semantics (funct3 011 treated as add)
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return a + b;
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    if (o_mem_we === 1'b1) mem[o_mem_addr[11:2]] = o_mem_wdata;
    #1;
  endtask

  task automatic drive(input logic rw, input logic mw, input logic irw, input logic ad,
                       input logic pcu, input logic br, input logic [1:0] rs,
                       input logic [1:0] sa, input logic [1:0] sbs, input logic [1:0] op);
    i_RegWrite = rw; i_MemWrite = mw; i_IRWrite = irw; i_AdSrc = ad;
    i_PCUpdate = pcu; i_Branch = br; i_ResultSrc = rs; i_ALUSrcA = sa;
    i_ALUSrcB = sbs; i_ALUOp = op;
  endtask

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    sb.push_back('{cyc_cnt, name, sel, v});
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_old = RST_PC;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic post_reset_checks();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_val("rst_opcode", SEL_OPC, 32'h13);
    expect_val("rst_addr", SEL_ADDR, RST_PC);
    expect_val("rst_wdata", SEL_WDATA, 32'd0);
    expect_val("rst_we", SEL_WE, 32'd0);
    #1;
    n_tests++;
    if (o_opcode !== 7'b0010011) begin
      n_fail++;
      $display("FAIL direct rst_opcode: got %h", o_opcode);
    end
    n_tests++;
    if (o_mem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL direct rst_addr: got %h, expected %h", o_mem_addr, RST_PC);
    end
    tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    tick();
    i_rst = 1'b0;
    model_reset();
    post_reset_checks();
  endtask

  // fetch (PC += 4, IR/OldPC load) followed by decode (branch target into ALUOut)
  task automatic front(input logic [31:0] instr);
    mem[m_pc[11:2]] = instr;
    drive(0, 0, 1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    expect_val("fetch_addr", SEL_ADDR, m_pc);
    expect_val("fetch_we", SEL_WE, 32'd0);
    tick();
    m_old = m_pc;
    m_pc  = m_pc + 32'd4;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    expect_val("opcode", SEL_OPC, {25'd0, instr[6:0]});
    tick();
  endtask

  task automatic probe(input logic [4:0] n);
    mem[m_pc[11:2]] = enc_s(12'd0, n, 5'd0);
    drive(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    expect_val($sformatf("probe_x%0d", n), SEL_WDATA, m_rf[n]);
    tick();
  endtask

  task automatic run_alu(input logic is_r, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                         input logic [11:0] imm);
    logic [31:0] instr, res;
    logic        alt_eff;
    instr   = is_r ? enc_r(alt ? 7'h20 : 7'h00, rs2, rs1, f3, rd)
                   : enc_i(imm, rs1, f3, rd, 7'b0010011);
    alt_eff = is_r ? alt : ((f3 == 3'd5) ? imm[10] : 1'b0);
    res     = alu_ref(f3, alt_eff, m_rf[rs1], is_r ? m_rf[rs2] : sext12(imm));
    front(instr);
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01, 2'b10);
    tick();
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    if (rd != 5'd0) m_rf[rd] = res;
  endtask

  task automatic run_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    logic [31:0] addr;
    addr = m_rf[rs1] + sext12(imm);
    front(enc_i(imm, rs1, 3'b010, rd, 7'b0000011));
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
    tick();
    drive(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_val("lw_addr", SEL_ADDR, addr);
    #1;
    n_tests++;
    if (o_mem_addr !== addr) begin
      n_fail++;
      $display("FAIL direct lw_addr: got %h, expected %h", o_mem_addr, addr);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    if (rd != 5'd0) m_rf[rd] = m_mem[addr[11:2]];
  endtask

  task automatic run_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    logic [31:0] addr;
    addr = m_rf[rs1] + sext12(imm);
    front(enc_s(imm, rs2, rs1));
    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
    tick();
    drive(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_val("sw_addr", SEL_ADDR, addr);
    expect_val("sw_wdata", SEL_WDATA, m_rf[rs2]);
    expect_val("sw_we", SEL_WE, 32'd1);
    #1;
    n_tests++;
    if (o_mem_we !== 1'b1 || o_mem_wdata !== m_rf[rs2]) begin
      n_fail++;
      $display("FAIL direct sw: we=%b wdata=%h, expected wdata %h", o_mem_we, o_mem_wdata,
               m_rf[rs2]);
    end
    tick();
    m_mem[addr[11:2]] = m_rf[rs2];
  endtask

  task automatic run_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                         input logic rst_mid);
    logic taken;
    taken = (m_rf[rs1] == m_rf[rs2]);
    front(enc_b(imm, rs2, rs1));
    i_rst = rst_mid;
    drive(0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 2'b01);
    expect_val("beq_zero", SEL_ZERO, {31'd0, taken});
    #1;
    n_tests++;
    if (o_zero !== taken) begin
      n_fail++;
      $display("FAIL direct beq_zero: got %b, expected %b", o_zero, taken);
    end
    tick();
    i_rst = 1'b0;
    if (rst_mid) begin
      model_reset();
      post_reset_checks();
    end else if (taken) begin
      m_pc = m_old + {{19{imm[12]}}, imm};
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 32'd0;
      m_mem[i] = 32'd0;
    end
    mem[32'h208 >> 2] = 32'hDEAD_BEEF;  m_mem[32'h208 >> 2] = 32'hDEAD_BEEF;
    mem[32'h20C >> 2] = 32'h0000_55AA;  m_mem[32'h20C >> 2] = 32'h0000_55AA;

    do_reset();
    probe(5'd1);
    probe(5'd31);

    run_alu(1'b0, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 12'd10);
    probe(5'd1);

    run_alu(1'b0, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 12'h200);
    run_lw(5'd3, 5'd2, 12'd8);
    probe(5'd3);
    run_lw(5'd3, 5'd2, 12'd12);
    run_sw(5'd3, 5'd2, 12'd4);
    run_lw(5'd4, 5'd2, 12'd4);
    probe(5'd4);

    run_alu(1'b0, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 12'd5);
    run_alu(1'b0, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 12'd7);
    run_alu(1'b1, 5'd5, 5'd1, 5'd2, 3'b000, 1'b1, 12'd0);
    run_alu(1'b0, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 12'hFF8);
    run_alu(1'b0, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 12'd1);
    run_alu(1'b1, 5'd6, 5'd1, 5'd7, 3'b101, 1'b1, 12'd0);
    run_alu(1'b1, 5'd8, 5'd1, 5'd2, 3'b010, 1'b0, 12'd0);
    run_alu(1'b1, 5'd0, 5'd1, 5'd2, 3'b000, 1'b1, 12'd0);
    probe(5'd5);
    probe(5'd6);
    probe(5'd8);
    probe(5'd0);

    // branch from 0x110 back to 0x100: taken, then not taken, then reset in the branch cycle
    do_reset();
    run_alu(1'b0, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 12'd3);
    run_alu(1'b0, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 12'd3);
    run_alu(1'b0, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 12'd4);
    run_alu(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 12'd0);
    run_beq(5'd1, 5'd2, -13'sd16, 1'b0);
    run_alu(1'b0, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 12'd9);
    run_alu(1'b0, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 12'd1);
    run_alu(1'b0, 5'd4, 5'd0, 5'd0, 3'b000, 1'b0, 12'd2);
    run_alu(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 12'd0);
    run_beq(5'd1, 5'd2, -13'sd16, 1'b0);
    run_alu(1'b0, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 12'd1);
    run_beq(5'd1, 5'd1, 13'd8, 1'b1);
    probe(5'd1);

    for (int k = 0; k < 40; k++) begin
      logic        is_r, alt;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      is_r = 1'($urandom_range(0, 1));
      alt  = 1'($urandom_range(0, 1));
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      f3   = 3'($urandom_range(0, 7));
      imm  = 12'($urandom_range(0, 4095));
      run_alu(is_r, rd, rs1, rs2, f3, alt, imm);
    end
    for (int r = 1; r < 8; r++) probe(5'(r));

    drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge i_clk);
    @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
